// File: rtl/fp_accel_pkg.sv
// Shared helpers for the accelerator result path: width derivations,
// tkeep generation and a parameter legality check.
package fp_accel_pkg;

  localparam int unsigned VEC_ID_WIDTH_DEF = 8;
  localparam int unsigned BUS_WIDTH_DEF    = 128;
  localparam int unsigned CNT_WIDTH_DEF    = 32;

  // Widest byte-enable vector the keep helper can produce (1024-bit bus).
  localparam int unsigned MAX_KEEP_W = 128;

  // One ID pair is {idA, idB}.
  function automatic int unsigned pair_width(input int unsigned vec_w);
    return 2 * vec_w;
  endfunction

  // Number of pair lanes in one output word.
  function automatic int unsigned lane_count(input int unsigned bus_w,
                                             input int unsigned vec_w);
    return bus_w / (2 * vec_w);
  endfunction

  // Pairs must be whole bytes and tile the bus exactly.
  function automatic bit params_legal(input int unsigned vec_w,
                                      input int unsigned bus_w);
    return (vec_w != 0) &&
           (((2 * vec_w) % 8) == 0) &&
           (bus_w >= 2 * vec_w) &&
           ((bus_w % (2 * vec_w)) == 0) &&
           ((bus_w / 8) <= MAX_KEEP_W);
  endfunction

  // Byte enables covering lanes 0..lane inclusive; lane 0 is the LSB.
  function automatic logic [MAX_KEEP_W-1:0] keep_mask(input int unsigned lane,
                                                      input int unsigned pair_bytes);
    logic [MAX_KEEP_W-1:0] ones;
    ones = '1;
    return ~(ones << ((lane + 1) * pair_bytes));
  endfunction

endpackage

// File: rtl/axis_word_reg.sv
// Single-entry stream register: holds one word with valid/ready semantics
// and accepts a new word in the same cycle the held one drains.
module axis_word_reg #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned KEEP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready_c,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_last
);

  // Free when empty or when the held word leaves this cycle.
  assign in_ready_c = !out_valid || out_ready;

  // Load on accept, otherwise hold until the consumer takes the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else if (in_valid && in_ready_c) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_keep  <= in_keep;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/id_pair_packer.sv
// Packs narrow ID-pair beats into full bus words, flushing a zero-padded
// partial word at frame end, and keeps per-frame pair/word counters.
module id_pair_packer
  import fp_accel_pkg::*;
#(
  parameter int unsigned VEC_ID_WIDTH = VEC_ID_WIDTH_DEF,
  parameter int unsigned BUS_WIDTH    = BUS_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH    = CNT_WIDTH_DEF
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic [2*VEC_ID_WIDTH-1:0]   S_AXIS_ID_PAIR_tdata,
  input  logic                        S_AXIS_ID_PAIR_tvalid,
  input  logic                        S_AXIS_ID_PAIR_tlast,
  output logic                        S_AXIS_ID_PAIR_tready,
  output logic [BUS_WIDTH-1:0]        M_AXIS_DATA_tdata,
  output logic [BUS_WIDTH/8-1:0]      M_AXIS_DATA_tkeep,
  output logic                        M_AXIS_DATA_tvalid,
  output logic                        M_AXIS_DATA_tlast,
  input  logic                        M_AXIS_DATA_tready,
  output logic [CNT_WIDTH-1:0]        o_PairCount,
  output logic [CNT_WIDTH-1:0]        o_WordCount,
  output logic                        o_FrameDone
);

  localparam int unsigned PAIR_WIDTH = pair_width(VEC_ID_WIDTH);
  localparam int unsigned PAIR_BYTES = PAIR_WIDTH / 8;
  localparam int unsigned LANES      = lane_count(BUS_WIDTH, VEC_ID_WIDTH);
  localparam int unsigned KEEP_W     = BUS_WIDTH / 8;
  localparam int unsigned PTR_W      = (LANES > 1) ? $clog2(LANES) : 1;

  if (!params_legal(VEC_ID_WIDTH, BUS_WIDTH)) begin : g_bad_params
    $error("id_pair_packer: VEC_ID_WIDTH/BUS_WIDTH do not tile the bus in whole bytes");
  end

  logic [PTR_W-1:0]     ptr_q;
  logic [BUS_WIDTH-1:0] pack_q;
  logic                 pair_restart_q;
  logic                 word_restart_q;

  logic                 s_ready_c;
  logic                 s_accept_c;
  logic                 complete_c;
  logic                 m_hs_c;
  logic [BUS_WIDTH-1:0] word_c;
  logic [KEEP_W-1:0]    keep_c;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign S_AXIS_ID_PAIR_tready = s_ready_c;

  // Handshakes, completion and the candidate word with the incoming pair merged in.
  always_comb begin
    s_accept_c = S_AXIS_ID_PAIR_tvalid && s_ready_c;
    m_hs_c     = M_AXIS_DATA_tvalid && M_AXIS_DATA_tready;
    complete_c = s_accept_c &&
                 ((ptr_q == PTR_W'(LANES - 1)) || S_AXIS_ID_PAIR_tlast);
    word_c     = pack_q |
                 (BUS_WIDTH'(S_AXIS_ID_PAIR_tdata) << (32'(ptr_q) * PAIR_WIDTH));
    keep_c     = KEEP_W'(keep_mask(32'(ptr_q), PAIR_BYTES));
  end

  // Lane-filling pack register; cleared whenever a word is handed off.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ptr_q  <= '0;
      pack_q <= '0;
    end else if (s_accept_c) begin
      if (complete_c) begin
        ptr_q  <= '0;
        pack_q <= '0;
      end else begin
        ptr_q  <= ptr_q + PTR_W'(1);
        pack_q <= word_c;
      end
    end
  end

  axis_word_reg #(
    .DATA_W (BUS_WIDTH),
    .KEEP_W (KEEP_W)
  ) u_out_reg (
    .clk        (ap_clk),
    .rst        (ap_rst),
    .in_valid   (complete_c),
    .in_ready_c (s_ready_c),
    .in_data    (word_c),
    .in_keep    (keep_c),
    .in_last    (S_AXIS_ID_PAIR_tlast),
    .out_valid  (M_AXIS_DATA_tvalid),
    .out_ready  (M_AXIS_DATA_tready),
    .out_data   (M_AXIS_DATA_tdata),
    .out_keep   (M_AXIS_DATA_tkeep),
    .out_last   (M_AXIS_DATA_tlast)
  );

  // Status counters: totals hold after a frame and restart at the next
  // frame's first event, so they stay readable between frames.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      o_PairCount    <= '0;
      o_WordCount    <= '0;
      o_FrameDone    <= 1'b0;
      pair_restart_q <= 1'b0;
      word_restart_q <= 1'b0;
    end else begin
      o_FrameDone <= m_hs_c && M_AXIS_DATA_tlast;
      if (s_accept_c) begin
        o_PairCount    <= pair_restart_q ? CNT_WIDTH'(1) : sat_inc(o_PairCount);
        pair_restart_q <= S_AXIS_ID_PAIR_tlast;
      end
      if (m_hs_c) begin
        o_WordCount    <= word_restart_q ? CNT_WIDTH'(1) : sat_inc(o_WordCount);
        word_restart_q <= M_AXIS_DATA_tlast;
      end
    end
  end

endmodule

// File: tb/tb_id_pair_packer.sv
// Randomised and directed bench for id_pair_packer with a queue-based
// reference model checked every cycle.
module tb_id_pair_packer;

  localparam int unsigned PW    = 16;
  localparam int unsigned LANES = 8;
  localparam int unsigned BW    = 128;
  localparam int unsigned KW    = 16;
  localparam int unsigned CW    = 32;

  logic           ap_clk = 1'b0;
  logic           ap_rst;
  logic [PW-1:0]  s_tdata;
  logic           s_tvalid;
  logic           s_tlast;
  logic           s_tready;
  logic [BW-1:0]  m_tdata;
  logic [KW-1:0]  m_tkeep;
  logic           m_tvalid;
  logic           m_tlast;
  logic           m_tready;
  logic [CW-1:0]  pair_cnt;
  logic [CW-1:0]  word_cnt;
  logic           frame_done;

  id_pair_packer dut (
    .ap_clk                (ap_clk),
    .ap_rst                (ap_rst),
    .S_AXIS_ID_PAIR_tdata  (s_tdata),
    .S_AXIS_ID_PAIR_tvalid (s_tvalid),
    .S_AXIS_ID_PAIR_tlast  (s_tlast),
    .S_AXIS_ID_PAIR_tready (s_tready),
    .M_AXIS_DATA_tdata     (m_tdata),
    .M_AXIS_DATA_tkeep     (m_tkeep),
    .M_AXIS_DATA_tvalid    (m_tvalid),
    .M_AXIS_DATA_tlast     (m_tlast),
    .M_AXIS_DATA_tready    (m_tready),
    .o_PairCount           (pair_cnt),
    .o_WordCount           (word_cnt),
    .o_FrameDone           (frame_done)
  );

  always #5 ap_clk = ~ap_clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed { logic [PW-1:0] d; logic l; } beat_t;
  typedef struct { logic [BW-1:0] d; logic [KW-1:0] k; logic l; } word_t;

  beat_t inq[$];
  word_t got[$];
  int    gap_pct = 0;
  int    mmode   = 0;
  int    fd_count = 0;
  bit    chk_en  = 1'b0;
  bit    drv_fire;

  task automatic push(input logic [PW-1:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    inq.push_back(b);
  endtask

  // Source driver: holds a beat until it is taken, optional random gaps.
  initial begin
    beat_t b;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    forever begin
      @(negedge ap_clk);
      drv_fire = s_tvalid && s_tready;
      @(posedge ap_clk);
      #1;
      if (drv_fire) s_tvalid = 1'b0;
      if (!s_tvalid && inq.size() > 0 && $urandom_range(99) >= 32'(gap_pct)) begin
        b = inq.pop_front();
        s_tdata  = b.d;
        s_tlast  = b.l;
        s_tvalid = 1'b1;
      end
    end
  end

  // Sink ready pattern: 0 always, 1 toggle, 2 random, 3 stalled.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge ap_clk);
      #1;
      case (mmode)
        1:       m_tready = ~m_tready;
        2:       m_tready = ($urandom_range(99) < 70);
        3:       m_tready = 1'b0;
        default: m_tready = 1'b1;
      endcase
    end
  end

  // Reference model state: pairs waiting for a word, one held output word.
  logic [PW-1:0]  mq[$];
  bit             mv, mlast, fd_m, plast, wlast;
  logic [BW-1:0]  mdata;
  logic [KW-1:0]  mkeep;
  logic [CW-1:0]  pc, wc;

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_step();
    bit acc, hs;
    if (ap_rst) begin
      mq.delete();
      mv = 0; mlast = 0; fd_m = 0; plast = 0; wlast = 0;
      mdata = '0; mkeep = '0; pc = '0; wc = '0;
    end else begin
      acc  = s_tvalid && (!mv || m_tready);
      hs   = mv && m_tready;
      fd_m = hs && mlast;
      if (hs) begin
        wc    = wlast ? 32'd1 : sat(wc);
        wlast = mlast;
        mv    = 0;
      end
      if (acc) begin
        pc    = plast ? 32'd1 : sat(pc);
        plast = s_tlast;
        mq.push_back(s_tdata);
        if (s_tlast || mq.size() == LANES) begin
          mdata = '0;
          mkeep = '0;
          foreach (mq[i]) begin
            mdata = mdata | (BW'(mq[i]) << (PW * i));
            mkeep[2*i +: 2] = 2'b11;
          end
          mlast = s_tlast;
          mv    = 1;
          mq.delete();
        end
      end
    end
  endtask

  // Compare DUT to model every cycle, then advance the model by one edge.
  initial begin
    forever begin
      @(negedge ap_clk);
      if (chk_en) begin
        chk("s_tready", 128'(s_tready), 128'(!mv || m_tready));
        chk("m_tvalid", 128'(m_tvalid), 128'(mv));
        if (mv) begin
          chk("m_tdata", 128'(m_tdata), 128'(mdata));
          chk("m_tkeep", 128'(m_tkeep), 128'(mkeep));
          chk("m_tlast", 128'(m_tlast), 128'(mlast));
        end
        chk("pair_count", 128'(pair_cnt), 128'(pc));
        chk("word_count", 128'(word_cnt), 128'(wc));
        chk("frame_done", 128'(frame_done), 128'(fd_m));
        if (m_tvalid && m_tready) got.push_back('{m_tdata, m_tkeep, m_tlast});
        if (frame_done) fd_count++;
      end
      model_step();
    end
  end

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge ap_clk);
      if (inq.size() == 0 && !s_tvalid && !m_tvalid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: idle timeout, got busy, want idle", name);
    end
    repeat (2) @(negedge ap_clk);
  endtask

  function automatic logic [BW-1:0] pack8(input logic [PW-1:0] base, input int first);
    logic [BW-1:0] w = '0;
    for (int i = 0; i < 8; i++) w = w | (BW'(base + PW'(first + i)) << (PW * i));
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] p4[64];
    logic [PW-1:0] rs[$];
    logic [PW-1:0] flat[$];
    logic [BW-1:0] e;
    bit ok;

    ap_rst = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    chk_en = 1'b1;
    @(negedge ap_clk);
    chk("rst_s_tready", 128'(s_tready), 128'(1'b1));
    chk("rst_m_tvalid", 128'(m_tvalid), 128'(1'b0));
    chk("rst_m_tdata", 128'(m_tdata), 128'(0));
    chk("rst_m_tkeep", 128'(m_tkeep), 128'(0));
    chk("rst_pair_count", 128'(pair_cnt), 128'(0));
    chk("rst_frame_done", 128'(frame_done), 128'(0));

    // Two full words, tlast on lane 7 of the second.
    got.delete(); fd_count = 0;
    for (int i = 0; i < 16; i++) push(16'h0100 + 16'(i), i == 15);
    wait_idle("t1");
    chk("t1_words", 128'(got.size()), 128'(2));
    if (got.size() == 2) begin
      chk("t1_w0_data", got[0].d, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
      chk("t1_w0_keep", 128'(got[0].k), 128'(16'hFFFF));
      chk("t1_w0_last", 128'(got[0].l), 128'(0));
      chk("t1_w1_data", got[1].d, 128'h010F_010E_010D_010C_010B_010A_0109_0108);
      chk("t1_w1_keep", 128'(got[1].k), 128'(16'hFFFF));
      chk("t1_w1_last", 128'(got[1].l), 128'(1));
    end
    chk("t1_pairs", 128'(pair_cnt), 128'(16));
    chk("t1_wordcnt", 128'(word_cnt), 128'(2));
    chk("t1_frame_done", 128'(fd_count), 128'(1));

    // Three-pair partial frame.
    got.delete();
    push(16'hAABB, 0); push(16'hCCDD, 0); push(16'hEEFF, 1);
    wait_idle("t2");
    chk("t2_words", 128'(got.size()), 128'(1));
    if (got.size() == 1) begin
      chk("t2_data", got[0].d, 128'h0000_EEFF_CCDD_AABB);
      chk("t2_keep", 128'(got[0].k), 128'(16'h003F));
      chk("t2_last", 128'(got[0].l), 128'(1));
    end
    chk("t2_pairs", 128'(pair_cnt), 128'(3));
    chk("t2_wordcnt", 128'(word_cnt), 128'(1));

    // Single pair: word visible exactly one cycle after acceptance.
    push(16'h1234, 1);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge ap_clk);
      if (s_tvalid && s_tready) begin ok = 1; break; end
    end
    chk("t3_accept_seen", 128'(ok), 128'(1));
    chk("t3_before", 128'(m_tvalid), 128'(0));
    @(negedge ap_clk);
    chk("t3_latency", 128'(m_tvalid), 128'(1));
    chk("t3_keep", 128'(m_tkeep), 128'(16'h0003));
    chk("t3_last", 128'(m_tlast), 128'(1));
    chk("t3_data", m_tdata, 128'h1234);
    wait_idle("t3");

    // 64 pairs with toggling sink ready.
    mmode = 1; got.delete();
    for (int i = 0; i < 64; i++) begin
      p4[i] = 16'($urandom);
      push(p4[i], i == 63);
    end
    wait_idle("t4");
    chk("t4_words", 128'(got.size()), 128'(8));
    if (got.size() == 8) begin
      for (int w = 0; w < 8; w++) begin
        e = '0;
        for (int l = 0; l < 8; l++) e = e | (BW'(p4[w*8 + l]) << (PW * l));
        chk($sformatf("t4_w%0d_data", w), got[w].d, e);
        chk($sformatf("t4_w%0d_last", w), 128'(got[w].l), 128'(w == 7));
      end
    end
    mmode = 0;
    repeat (2) @(posedge ap_clk);

    // Sink stalled for 20 cycles after the first word completes.
    mmode = 3; got.delete();
    repeat (2) @(posedge ap_clk);
    for (int i = 0; i < 16; i++) push(16'h2000 + 16'(i), i == 15);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge ap_clk);
      if (m_tvalid) begin ok = 1; break; end
    end
    chk("t5_word_seen", 128'(ok), 128'(1));
    repeat (20) @(negedge ap_clk);
    chk("t5_s_tready", 128'(s_tready), 128'(0));
    chk("t5_hold_valid", 128'(m_tvalid), 128'(1));
    chk("t5_hold_data", m_tdata, pack8(16'h2000, 0));
    chk("t5_hold_keep", 128'(m_tkeep), 128'(16'hFFFF));
    chk("t5_hold_last", 128'(m_tlast), 128'(0));
    chk("t5_pairs_stalled", 128'(pair_cnt), 128'(8));
    mmode = 0;
    wait_idle("t5");
    chk("t5_words", 128'(got.size()), 128'(2));
    if (got.size() == 2) begin
      chk("t5_w1_data", got[1].d, pack8(16'h2000, 8));
      chk("t5_w1_last", 128'(got[1].l), 128'(1));
    end

    // Reset in mid-frame discards the partial word.
    got.delete();
    for (int i = 0; i < 5; i++) push(16'h4000 + 16'(i), 0);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge ap_clk);
      if (inq.size() == 0 && !s_tvalid) begin ok = 1; break; end
    end
    chk("t6_fed", 128'(ok), 128'(1));
    @(posedge ap_clk); #1;
    ap_rst = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("t6_rst_pairs", 128'(pair_cnt), 128'(0));
    push(16'h3001, 0); push(16'h3002, 1);
    wait_idle("t6");
    chk("t6_words", 128'(got.size()), 128'(1));
    if (got.size() == 1) begin
      chk("t6_data", got[0].d, 128'h3002_3001);
      chk("t6_keep", 128'(got[0].k), 128'(16'h000F));
      chk("t6_last", 128'(got[0].l), 128'(1));
    end
    chk("t6_pairs", 128'(pair_cnt), 128'(2));
    chk("t6_wordcnt", 128'(word_cnt), 128'(1));

    // Random frames, gaps and backpressure; scoreboard on pair order.
    mmode = 2; gap_pct = 30; got.delete();
    for (int i = 0; i < 300; i++) begin
      logic [PW-1:0] d;
      d = PW'($urandom);
      rs.push_back(d);
      push(d, ($urandom_range(5) == 0) || (i == 299));
    end
    wait_idle("rand");
    foreach (got[w])
      for (int l = 0; l < 8; l++)
        if (got[w].k[2*l]) flat.push_back(got[w].d[PW*l +: PW]);
    chk("rand_pair_total", 128'(flat.size()), 128'(rs.size()));
    if (flat.size() == rs.size())
      foreach (rs[i]) chk($sformatf("rand_pair%0d", i), 128'(flat[i]), 128'(rs[i]));
    mmode = 0; gap_pct = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
